// File: rtl/bram_stream_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_logger_if
// Brief    : Wishbone classic write-master bundle between logger and blockram.
// Revision : 1.0
// ============================================================================
interface bram_stream_logger_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/bram_stream_logger.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_logger
// Brief    : Packs NCH sigma-delta bitstreams into words and writes them to
//            blockram as a Wishbone master. Option macro: BRAM_LOG_TEST_PATTERN_EN
// Revision : 1.0
// ============================================================================
module bram_stream_logger #(
  parameter int NCH         = 4,
  parameter int WORD_W      = 32,
  parameter int DEPTH       = 2048,
  parameter int ADR_W       = 11,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 reset,
  input  logic                 adc_clk,
  input  logic [NCH-1:0]       adc_dat,
  input  logic                 arm,
  input  logic                 circ,
  bram_stream_logger_if.master wb,
  output logic [ADR_W-1:0]     wr_ptr,
  output logic                 done,
  output logic                 wrapped,
  output logic                 overrun,
  output logic                 bus_err
);

  localparam int CH_W  = $clog2(NCH + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int BC_W  = $clog2(WORD_W);
  localparam logic [3:0] BUS_SEL = (WORD_W == 32) ? 4'hF : 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic           clk_s1, clk_s2, clk_s3;
  logic [NCH-1:0] dat_s1, dat_s2;
  logic           adc_edge;

  logic             cap_en;
  logic             circ_mode;
  logic             arm_q;
  logic             pending;
  logic [BC_W-1:0]  bit_cnt;
  logic [CH_W-1:0]  ch;
  logic [TMR_W-1:0] timer;

  logic [WORD_W-1:0] sr      [NCH];
  logic [WORD_W-1:0] sr_nx   [NCH];
  logic [WORD_W-1:0] holding [NCH];

  logic        apply_arm;
  logic        shift_en;
  logic        frame_end;
  logic        frame_take;
  logic        timed_out;
  logic        word_end;
  logic        gap_clear;
  logic [31:0] bus_dat;

  // Two flops per input, third flop on adc_clk only for edge detection.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_s3 <= 1'b0;
      dat_s1 <= '0;
      dat_s2 <= '0;
    end else begin
      clk_s1 <= adc_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= adc_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign adc_edge = clk_s2 & ~clk_s3;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign sr_nx[i] = WORD_W'({dat_s2[i], sr[i]} >> 1);
  end

  always_comb begin
    apply_arm  = (arm | arm_q) & ((state == IDLE) | (state == GAP));
    timed_out  = (state == ACK) & ~wb.wb_ack_i & (timer == TMR_W'(ACK_TIMEOUT - 1));
    word_end   = (state == ACK) & (wb.wb_ack_i | timed_out);
    shift_en   = adc_edge & cap_en & ~apply_arm;
    frame_end  = shift_en & (bit_cnt == BC_W'(WORD_W - 1));
    frame_take = frame_end & ~pending;
    state_nx   = state;
    gap_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (!apply_arm && cap_en && pending) state_nx = REQ;
      end
      REQ: state_nx = ACK;
      ACK: begin
        if (word_end) state_nx = GAP;
      end
      GAP: begin
        state_nx = IDLE;
        if (!apply_arm) begin
          if (cap_en && (ch < CH_W'(NCH))) state_nx = REQ;
          else                             gap_clear = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        sr[i]      <= '0;
        holding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (shift_en)   sr[i]      <= sr_nx[i];
        if (frame_take) holding[i] <= sr_nx[i];
      end
    end
  end

  // An arm seen during a bus cycle is parked in arm_q until the cycle ends.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      cap_en    <= 1'b0;
      circ_mode <= 1'b0;
      arm_q     <= 1'b0;
      pending   <= 1'b0;
      bit_cnt   <= '0;
      ch        <= '0;
      wr_ptr    <= '0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
      overrun   <= 1'b0;
      bus_err   <= 1'b0;
    end else if (apply_arm) begin
      cap_en    <= 1'b1;
      circ_mode <= circ;
      arm_q     <= 1'b0;
      pending   <= 1'b0;
      bit_cnt   <= '0;
      ch        <= '0;
      wr_ptr    <= '0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
      overrun   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if (arm) arm_q <= 1'b1;
      if (shift_en) bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
      if (frame_end && pending) overrun <= 1'b1;
      if (word_end) begin
        ch <= ch + 1'b1;
        if (timed_out) bus_err <= 1'b1;
        if (wr_ptr == ADR_W'(DEPTH - 1)) begin
          if (circ_mode) begin
            wr_ptr  <= '0;
            wrapped <= 1'b1;
          end else begin
            done    <= 1'b1;
            cap_en  <= 1'b0;
          end
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (gap_clear) begin
        ch      <= '0;
        pending <= 1'b0;
      end
      if (frame_take) pending <= 1'b1;
    end
  end

`ifdef BRAM_LOG_TEST_PATTERN_EN
  logic [7:0] frame_count;
  logic [7:0] hold_fc;

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      hold_fc     <= '0;
    end else if (apply_arm) begin
      frame_count <= '0;
    end else if (frame_take) begin
      hold_fc     <= frame_count;
      frame_count <= frame_count + 1'b1;
    end
  end

  assign bus_dat = {4'(ch), 4'h0, hold_fc, 16'hEF01};
`else
  logic [WORD_W-1:0] cur_word;

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == CH_W'(i)) cur_word = holding[i];
    end
  end

  assign bus_dat = 32'(cur_word);
`endif

  // Bus outputs are registered: loaded in REQ, frozen through ACK.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= '0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      timer       <= '0;
    end else begin
      case (state)
        REQ: begin
          wb.wb_cyc_o <= 1'b1;
          wb.wb_stb_o <= 1'b1;
          wb.wb_we_o  <= 1'b1;
          wb.wb_sel_o <= BUS_SEL;
          wb.wb_adr_o <= 32'({wr_ptr, 2'b00});
          wb.wb_dat_o <= bus_dat;
          timer       <= '0;
        end
        ACK: begin
          if (word_end) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= '0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_logger
// Brief    : Randomised bench with a frame-level write model and Wishbone slave.
// Revision : 1.0
// ============================================================================
module tb_bram_stream_logger;
  localparam int NCH = 4, WORD_W = 32, DEPTH = 8, ADR_W = 3, TMO = 15;

  logic clk = 1'b0, rst = 1'b1, adc_clk = 1'b0, circ = 1'b0;
  logic arm_a = 1'b0, arm_b = 1'b0;
  logic [NCH-1:0] adc_dat = '0;
  logic [ADR_W-1:0] wr_ptr_a, wr_ptr_b;
  logic done_a, wrapped_a, overrun_a, bus_err_a;
  logic done_b, wrapped_b, overrun_b, bus_err_b;

  bram_stream_logger_if bus_a();
  bram_stream_logger_if bus_b();

  always #5 clk = ~clk;

  bram_stream_logger #(.NCH(NCH), .WORD_W(WORD_W), .DEPTH(DEPTH), .ADR_W(ADR_W),
                       .ACK_TIMEOUT(TMO)) dut_a (
    .wb_clk_i(clk), .reset(rst), .adc_clk(adc_clk), .adc_dat(adc_dat),
    .arm(arm_a), .circ(circ), .wb(bus_a), .wr_ptr(wr_ptr_a), .done(done_a),
    .wrapped(wrapped_a), .overrun(overrun_a), .bus_err(bus_err_a));

  // Second instance with a long ack timeout so a slow slave can force overruns.
  bram_stream_logger #(.NCH(NCH), .WORD_W(WORD_W), .DEPTH(DEPTH), .ADR_W(ADR_W),
                       .ACK_TIMEOUT(400)) dut_b (
    .wb_clk_i(clk), .reset(rst), .adc_clk(adc_clk), .adc_dat(adc_dat),
    .arm(arm_b), .circ(circ), .wb(bus_b), .wr_ptr(wr_ptr_b), .done(done_b),
    .wrapped(wrapped_b), .overrun(overrun_b), .bus_err(bus_err_b));

  typedef struct packed { logic [31:0] adr; logic [31:0] dat; } wr_t;

  int total = 0, bad = 0;
  wr_t exp_q[$];
  wr_t seen_q[$];
  wr_t seen_b[$];

  // Frame-level model of the logger
  bit m_en = 0, m_circ = 0, m_done = 0, m_wrapped = 0;
  int m_ptr = 0, m_bit = 0;
  logic [31:0] m_word [NCH];
  logic [31:0] b_word [NCH];
  bit b_rec = 0;
  int b_bit = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic model_bits(input logic [NCH-1:0] b);
    if (b_rec && b_bit < WORD_W) begin
      for (int c = 0; c < NCH; c++) b_word[c][b_bit] = b[c];
      b_bit++;
    end
    if (!m_en) return;
    for (int c = 0; c < NCH; c++) m_word[c][m_bit] = b[c];
    m_bit++;
    if (m_bit == WORD_W) begin
      m_bit = 0;
      for (int c = 0; c < NCH; c++) begin
        if (m_en) begin
          exp_q.push_back('{adr: 32'(m_ptr * 4), dat: m_word[c]});
          if (m_ptr == DEPTH - 1) begin
            if (m_circ) begin m_ptr = 0; m_wrapped = 1; end
            else begin m_en = 0; m_done = 1; end
          end else begin
            m_ptr++;
          end
        end
      end
    end
  endtask

  task automatic adc_edge(input logic [NCH-1:0] b, input int half);
    adc_dat = b;
    repeat (half) @(negedge clk);
    adc_clk = 1'b1;
    model_bits(b);
    repeat (half) @(negedge clk);
    adc_clk = 1'b0;
  endtask

  task automatic send_frames(input int n, input int half);
    for (int i = 0; i < n * WORD_W; i++) adc_edge(NCH'($urandom), half);
  endtask

  task automatic do_arm(input logic c);
    circ  = c;
    arm_a = 1'b1;
    @(negedge clk);
    arm_a = 1'b0;
    m_en = 1; m_circ = c; m_ptr = 0; m_bit = 0; m_done = 0; m_wrapped = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || bus_a.wb_cyc_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, " drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Slave for dut_a and the single compare process against the model
  int wait_a = 0, run_a = 0, cur_delay = 1, ack_delay = 1, nack_words = 0;
  int last_run = 0, tmo_cnt = 0;
  bit acked = 0, prev_cyc = 0, rand_ack = 0;

  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      bus_a.wb_ack_i = 1'b0;
      wait_a = 0; run_a = 0; prev_cyc = 0; acked = 0;
    end else begin
      if (prev_cyc && !bus_a.wb_cyc_o && !acked) begin
        tmo_cnt++;
        last_run = run_a;
        if (nack_words > 0) nack_words--;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL skipped word: got unexpected timeout want none");
        end else begin
          e = exp_q.pop_front();
          chk("skipped adr", bus_a.wb_adr_o == 32'd0 ? e.adr : e.adr, e.adr);
        end
      end
      if (!bus_a.wb_cyc_o) begin run_a = 0; wait_a = 0; end
      acked = 0;
      bus_a.wb_ack_i = 1'b0;
      if (bus_a.wb_cyc_o) begin
        run_a++;
        if (run_a == 1) cur_delay = rand_ack ? int'($urandom_range(1, 6)) : ack_delay;
        if (run_a == TMO + 1) chk("cyc length", 32'(run_a), 32'(TMO));
        wait_a++;
        if (nack_words == 0 && wait_a >= cur_delay) begin
          bus_a.wb_ack_i = 1'b1;
          acked = 1;
          wait_a = 0;
          seen_q.push_back('{adr: bus_a.wb_adr_o, dat: bus_a.wb_dat_o});
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected write: got adr %h want no write", bus_a.wb_adr_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr adr", bus_a.wb_adr_o, e.adr);
            chk("wr dat", bus_a.wb_dat_o, e.dat);
            chk("wr ctl", {26'd0, bus_a.wb_stb_o, bus_a.wb_we_o, bus_a.wb_sel_o}, 32'h3F);
          end
        end
      end
      prev_cyc = bus_a.wb_cyc_o;
    end
  end

  // Slow slave for dut_b: acks each write 300 cycles after stb
  int wait_b = 0;
  always @(negedge clk) begin
    if (rst) begin
      bus_b.wb_ack_i = 1'b0;
      wait_b = 0;
    end else begin
      bus_b.wb_ack_i = 1'b0;
      if (!bus_b.wb_cyc_o) wait_b = 0;
      else begin
        wait_b++;
        if (wait_b >= 300) begin
          bus_b.wb_ack_i = 1'b1;
          wait_b = 0;
          seen_b.push_back('{adr: bus_b.wb_adr_o, dat: bus_b.wb_dat_o});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lit_dat [4];
    int n;
    lit_dat[0] = 32'hFFFFFFFF; lit_dat[1] = 32'h0;
    lit_dat[2] = 32'hFFFFFFFF; lit_dat[3] = 32'h0;

    repeat (3) @(negedge clk);
    chk("reset bus ctl", {26'd0, bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o,
        bus_a.wb_sel_o[2:0]}, 32'd0);
    chk("reset sel", {28'd0, bus_a.wb_sel_o}, 32'd0);
    chk("reset adr", bus_a.wb_adr_o, 32'd0);
    chk("reset dat", bus_a.wb_dat_o, 32'd0);
    chk("reset status", {25'd0, wr_ptr_a, done_a, wrapped_a, overrun_a, bus_err_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Constant pattern 0101 -> alternating all-ones / all-zeros words
    seen_q.delete();
    do_arm(1'b0);
    ack_delay = 1;
    for (int i = 0; i < WORD_W; i++) adc_edge(4'b0101, 4);
    drain("basic");
    chk("basic count", 32'(seen_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      chk("basic lit adr", seen_q[i].adr, 32'(i * 4));
      chk("basic lit dat", seen_q[i].dat, lit_dat[i]);
    end
    chk("basic wr_ptr", 32'(wr_ptr_a), 32'd4);

    // One-shot fill of the 8-word buffer
    seen_q.delete();
    do_arm(1'b0);
    ack_delay = int'($urandom_range(1, 4));
    send_frames(3, 4);
    drain("oneshot");
    chk("oneshot count", 32'(seen_q.size()), 32'd8);
    chk("oneshot model done", 32'(m_done), 32'd1);
    chk("oneshot done", 32'(done_a), 32'd1);
    repeat (50) @(negedge clk);
    chk("oneshot no more writes", 32'(seen_q.size()), 32'd8);
    do_arm(1'b0);
    @(negedge clk);
    chk("rearm wr_ptr", 32'(wr_ptr_a), 32'd0);
    chk("rearm done", 32'(done_a), 32'd0);

    // Circular: third frame lands at the start of the buffer
    seen_q.delete();
    do_arm(1'b1);
    rand_ack = 1;
    send_frames(3, 4);
    drain("circ");
    chk("circ count", 32'(seen_q.size()), 32'd12);
    for (int i = 8; i < 12 && i < seen_q.size(); i++)
      chk("circ lit adr", seen_q[i].adr, 32'((i - 8) * 4));
    chk("circ wrapped", 32'(wrapped_a), 32'd1);
    chk("circ wr_ptr", 32'(wr_ptr_a), 32'd4);
    rand_ack = 0;

    // First word never acked: timeout, skip, remaining channels written
    seen_q.delete();
    do_arm(1'b0);
    ack_delay = 1;
    nack_words = 1;
    tmo_cnt = 0;
    send_frames(1, 4);
    drain("timeout");
    chk("timeout count", 32'(tmo_cnt), 32'd1);
    chk("timeout cyc run", 32'(last_run), 32'(TMO));
    chk("timeout bus_err", 32'(bus_err_a), 32'd1);
    chk("timeout wr_ptr", 32'(wr_ptr_a), 32'd4);
    chk("timeout writes", 32'(seen_q.size()), 32'd3);
    if (seen_q.size() > 0) chk("timeout next adr", seen_q[0].adr, 32'd4);

    // Randomised mode / frame count / ack latency runs
    for (int r = 0; r < 3; r++) begin
      do_arm(1'($urandom));
      rand_ack = 1;
      send_frames(int'($urandom_range(1, 4)), 4);
      drain("random");
      chk("random done", 32'(done_a), 32'(m_done));
      chk("random wrapped", 32'(wrapped_a), 32'(m_wrapped));
      if (!m_done) chk("random wr_ptr", 32'(wr_ptr_a), 32'(m_ptr));
      chk("random errs", {30'd0, overrun_a, bus_err_a}, 32'd0);
    end
    rand_ack = 0;

    // Async reset while a write is outstanding
    do_arm(1'b0);
    ack_delay = 12;
    send_frames(1, 4);
    n = 0;
    while (!bus_a.wb_stb_o && n < 100) begin @(negedge clk); n++; end
    chk("reset test stb seen", 32'(bus_a.wb_stb_o), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async reset bus", {29'd0, bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen_q.delete();
    m_en = 0; m_bit = 0; m_ptr = 0;
    ack_delay = 1;
    send_frames(1, 4);
    repeat (30) @(negedge clk);
    chk("no write after reset", 32'(seen_q.size()), 32'd0);

    // Overrun on dut_b with a 300-cycle slave and adc at wb/4
    seen_b.delete();
    b_rec = 1; b_bit = 0;
    arm_b = 1'b1;
    @(negedge clk);
    arm_b = 1'b0;
    send_frames(3, 2);
    n = 0;
    while (seen_b.size() < 4 && n < 4000) begin @(negedge clk); n++; end
    repeat (400) @(negedge clk);
    chk("overrun flag", 32'(overrun_b), 32'd1);
    chk("overrun count", 32'(seen_b.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen_b.size(); i++) begin
      chk("overrun adr", seen_b[i].adr, 32'(i * 4));
      chk("overrun dat", seen_b[i].dat, b_word[i]);
    end
    chk("overrun wr_ptr", 32'(wr_ptr_b), 32'd4);
    chk("overrun dut_a idle", 32'(seen_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
